tnn_infer_sequencer: RTL and testbench

- Front-end controller for the 7-input, 2-bit-per-feature approximate classifier core (14-bit feature vector in, 1-bit class out, purely combinational).
- Accepts features serially over a valid/ready stream and packs them into the core's input vector.
- Holds the vector stable for a settle cycle, registers the core's class bit, and returns it over a valid/ready result handshake.
- Sits between the sample-streaming interface and one instance of the evolved classifier.

---
 rtl/tnn_infer_sequencer.sv | 130 +++++++++++++
 tb/tb_tnn_infer_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tnn_infer_sequencer.sv
// Serial front-end for the 7x2-bit approximate classifier: packs feature beats, settles, returns class.
// Optional result statistics counters are enabled by defining TNN_SEQ_STATS_EN.
module tnn_infer_sequencer #(
  parameter int N_FEAT = 7,
  parameter int FEAT_W = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] core_vec,
  input  logic                     core_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_class,
  output logic                     m_err,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         stat_total,
  output logic [CNT_W-1:0]         stat_pos
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_SETTLE, ST_RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [1:0]       scnt;
  logic             err;
  logic             beat_acc, last_slot, settle_done, res_hs;

  always_comb begin
    beat_acc    = s_valid & s_ready;
    last_slot   = (idx == IDX_W'(N_FEAT - 1));
    settle_done = (state == ST_SETTLE) && (scnt == 2'(SETTLE - 1));
    res_hs      = (state == ST_RESP) && m_valid && m_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (beat_acc) begin
          if (last_slot)   state_nxt = s_last ? ST_SETTLE : ST_DRAIN;
          else if (s_last) state_nxt = ST_SETTLE;
        end
      end
      ST_DRAIN:  if (beat_acc && s_last) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done)        state_nxt = ST_RESP;
      ST_RESP:   if (res_hs)             state_nxt = ST_LOAD;
      default:                           state_nxt = ST_LOAD;
    endcase
  end

  // s_ready is a flop fed from the next state, so it never depends combinationally on m_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOAD;
      s_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      scnt     <= '0;
      err      <= 1'b0;
      core_vec <= '0;
      m_valid  <= 1'b0;
      m_class  <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      if (res_hs)
        idx <= '0;
      else if (state == ST_LOAD && beat_acc && !last_slot)
        idx <= idx + 1'b1;

      scnt <= (state == ST_SETTLE) ? scnt + 1'b1 : 2'd0;

      if (state == ST_LOAD && beat_acc) begin
        if (last_slot)   err <= ~s_last;
        else if (s_last) err <= 1'b1;
        else             err <= 1'b0;
        // a short frame zero-fills every slot above the final beat
        for (int k = 0; k < N_FEAT; k++) begin
          if (k == int'(idx))
            core_vec[FEAT_W*k +: FEAT_W] <= s_data;
          else if (s_last && k > int'(idx))
            core_vec[FEAT_W*k +: FEAT_W] <= '0;
        end
      end

      if (settle_done) begin
        m_valid <= 1'b1;
        m_class <= core_out & ~err;
        m_err   <= err;
      end else if (res_hs) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef TNN_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total <= '0;
      stat_pos   <= '0;
    end else if (stat_clr) begin
      stat_total <= '0;
      stat_pos   <= '0;
    end else if (res_hs) begin
      if (stat_total != '1) stat_total <= stat_total + 1'b1;
      if (m_class && !m_err && stat_pos != '1) stat_pos <= stat_pos + 1'b1;
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_total      = '0;
  assign stat_pos        = '0;
`endif

endmodule

// File: tb/tb_tnn_infer_sequencer.sv
// Scoreboard bench for tnn_infer_sequencer; stats checks follow TNN_SEQ_STATS_EN.
module tb_tnn_infer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [1:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic [13:0] core_vec;
  logic        core_out;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_class;
  logic        m_err;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_total;
  logic [15:0] stat_pos;
  logic        force_one = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  // classifier stand-in: fires only on the all-ones vector unless forced
  assign core_out = force_one | (core_vec == 14'h3FFF);

  tnn_infer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .core_vec(core_vec), .core_out(core_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err),
    .stat_clr(stat_clr), .stat_total(stat_total), .stat_pos(stat_pos)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("m_class", int'(m_class), int'(e[1]));
        check("m_err", int'(m_err), int'(e[0]));
      end
    end
  end

  task automatic send_frame(input logic [17:0] beats, input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      s_valid = 1'b1;
      s_data  = beats[2*i +: 2];
      s_last  = (i == n - 1);
      while (!s_ready && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      if (!s_ready) check("s_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!m_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!m_valid) check("m_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (m_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (m_valid) check("m_valid_stuck", 1, 0);
  endtask

  initial begin
    #2;
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_core_vec", int'(core_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_rst", int'(s_ready), 1);

    // nominal sample with latency probe
    exp_q.push_back(2'b10);
    send_frame(18'h03FFF, 7);
    check("nom_core_vec", int'(core_vec), 14'h3FFF);
    check("nom_settle_s_ready", int'(s_ready), 0);
    check("nom_m_valid_early", int'(m_valid), 0);
    @(posedge clk); #1;
    check("nom_m_valid_latency", int'(m_valid), 1);
    wait_idle();
    check("nom_s_ready_after_hs", int'(s_ready), 1);

    // packing order
    exp_q.push_back(2'b00);
    send_frame(18'h03939, 7);
    check("pack_core_vec", int'(core_vec), 14'h3939);
    wait_valid();
    wait_idle();

    // short frame, classifier forced high
    force_one = 1'b1;
    exp_q.push_back(2'b01);
    send_frame(18'h0002A, 3);
    check("short_core_vec", int'(core_vec), 14'h002A);
    wait_valid();
    wait_idle();
    force_one = 1'b0;

    // long frame: trailing beats discarded
    exp_q.push_back(2'b01);
    send_frame(18'h07FFF, 9);
    check("long_core_vec", int'(core_vec), 14'h3FFF);
    wait_valid();
    wait_idle();
    exp_q.push_back(2'b10);
    send_frame(18'h03FFF, 7);
    wait_valid();
    wait_idle();

    // backpressure
    m_ready = 1'b0;
    exp_q.push_back(2'b10);
    send_frame(18'h03FFF, 7);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_m_class", int'(m_class), 1);
      check("bp_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_idle();

    // reset during RESP discards the pending result
    m_ready = 1'b0;
    send_frame(18'h03FFF, 7);
    wait_valid();
    rst_n = 1'b0;
    #1;
    check("rst_mid_m_valid", int'(m_valid), 0);
    check("rst_mid_s_ready", int'(s_ready), 0);
    check("rst_mid_core_vec", int'(core_vec), 0);
    m_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_s_ready_up", int'(s_ready), 1);
    exp_q.push_back(2'b00);
    send_frame(18'h03939, 7);
    wait_valid();
    wait_idle();

`ifdef TNN_SEQ_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_total_clr", int'(stat_total), 0);
    check("stat_pos_clr", int'(stat_pos), 0);
    exp_q.push_back(2'b10);
    send_frame(18'h03FFF, 7);
    wait_valid(); wait_idle();
    exp_q.push_back(2'b00);
    send_frame(18'h03939, 7);
    wait_valid(); wait_idle();
    exp_q.push_back(2'b01);
    send_frame(18'h0002A, 3);
    wait_valid(); wait_idle();
    check("stat_total_3", int'(stat_total), 3);
    check("stat_pos_1", int'(stat_pos), 1);
    m_ready = 1'b0;
    exp_q.push_back(2'b10);
    send_frame(18'h03FFF, 7);
    wait_valid();
    stat_clr = 1'b1;
    m_ready  = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_total_clr_wins", int'(stat_total), 0);
    check("stat_pos_clr_wins", int'(stat_pos), 0);
    wait_idle();
`else
    check("stat_total_off", int'(stat_total), 0);
    check("stat_pos_off", int'(stat_pos), 0);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
